// File: rtl/hf_scoreboard_pkg.sv
// Shared definitions for the hardfloat result scoreboard: exception flag layout,
// format width helpers and the RUN/ABORT state encoding.
package hf_scoreboard_pkg;

    localparam int EXC_W  = 5;
    localparam int EXC_NV = 4;
    localparam int EXC_DZ = 3;
    localparam int EXC_OF = 2;
    localparam int EXC_UF = 1;
    localparam int EXC_NX = 0;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_ABORT = 1'b1
    } sb_state_e;

    function automatic int ieee_w(input int exp_w, input int sig_w);
        return exp_w + sig_w;
    endfunction

    // Recoded format carries one extra exponent bit.
    function automatic int rec_w(input int exp_w, input int sig_w);
        return exp_w + sig_w + 1;
    endfunction

endpackage

// File: rtl/hf_sync_fifo.sv
// Single-clock FIFO holding expected results; head is the oldest entry, read
// combinationally. Pushes while full and pops while empty are ignored.
module hf_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/hf_result_scoreboard.sv
// Queues expected hardfloat results at issue, compares them against DUT results in
// order, and keeps test/error counts with a progress strobe and sticky abort.
module hf_result_scoreboard
    import hf_scoreboard_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int SIG_W      = 24,
    parameter int DEPTH      = 8,
    parameter int MAX_ERRORS = 20,
    parameter int REPORT_INT = 10000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [ieee_w(EXP_W,SIG_W)-1:0]  exp_ieee,
    input  logic [rec_w(EXP_W,SIG_W)-1:0]   exp_recoded,
    input  logic [EXC_W-1:0]                exp_exc,
    input  logic                            res_valid,
    input  logic [ieee_w(EXP_W,SIG_W)-1:0]  res_ieee,
    input  logic [rec_w(EXP_W,SIG_W)-1:0]   res_recoded,
    input  logic [EXC_W-1:0]                res_exc,
    output logic                            check,
    output logic                            pass,
    output logic [31:0]                     mis_index,
    output logic [31:0]                     test_count,
    output logic [15:0]                     error_count,
    output logic                            progress,
    output logic                            underflow_err,
    output logic                            abort
);
    localparam int IW = ieee_w(EXP_W, SIG_W);
    localparam int RW = rec_w(EXP_W, SIG_W);

    // Entry layout depends on the format parameters, so it is declared here.
    typedef struct packed {
        logic [IW-1:0]    ieee;
        logic [RW-1:0]    recoded;
        logic [EXC_W-1:0] exc;
    } entry_t;

    entry_t    w_push_ent;
    entry_t    w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_match;
    logic      w_abort;
    logic      w_hit_limit;
    logic [15:0] w_err_nxt;
    sb_state_e r_state;
    sb_state_e w_state_nxt;

    logic        r_check;
    logic        r_pass;
    logic        r_progress;
    logic        r_underflow;
    logic [31:0] r_mis_index;
    logic [31:0] r_test_count;
    logic [31:0] r_prog_cnt;
    logic [15:0] r_error_count;

    assign w_abort     = (r_state == SB_ABORT);
    assign issue_ready = reset_n && !w_full && !w_abort;
    assign w_push      = issue_valid && issue_ready;
    assign w_pop       = res_valid && !w_empty && !w_abort;
    assign w_push_ent  = '{ieee: exp_ieee, recoded: exp_recoded, exc: exp_exc};
    assign w_match     = (w_head.ieee == res_ieee) && (w_head.recoded == res_recoded)
                         && (w_head.exc == res_exc);
    assign w_err_nxt   = r_error_count + 16'd1;
    assign w_hit_limit = w_pop && !w_match && (r_error_count != '1)
                         && (w_err_nxt == 16'(MAX_ERRORS));

    hf_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_ent),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= SB_RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == SB_RUN && w_hit_limit) w_state_nxt = SB_ABORT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_check       <= 1'b0;
            r_pass        <= 1'b0;
            r_progress    <= 1'b0;
            r_underflow   <= 1'b0;
            r_mis_index   <= '0;
            r_test_count  <= '0;
            r_error_count <= '0;
            r_prog_cnt    <= '0;
        end else begin
            r_check    <= w_pop;
            r_pass     <= w_pop && w_match;
            r_progress <= w_pop && (r_prog_cnt == '0);
            if (w_pop) begin
                r_mis_index <= r_test_count;
                if (r_test_count != '1)                r_test_count  <= r_test_count + 32'd1;
                if (!w_match && r_error_count != '1)   r_error_count <= w_err_nxt;
                r_prog_cnt <= (r_prog_cnt == '0) ? 32'(REPORT_INT - 1) : r_prog_cnt - 32'd1;
            end
            // No bypass: a result against an empty FIFO is a harness error even if
            // the matching vector is being issued in the same cycle.
            if (res_valid && w_empty && !w_abort) r_underflow <= 1'b1;
        end
    end

    assign check         = r_check;
    assign pass          = r_pass;
    assign progress      = r_progress;
    assign mis_index     = r_mis_index;
    assign test_count    = r_test_count;
    assign error_count   = r_error_count;
    assign underflow_err = r_underflow;
    assign abort         = w_abort;

endmodule

// File: tb/tb_hf_result_scoreboard.sv
// Scoreboard bench for hf_result_scoreboard: a queue model of issued vectors drives
// expected check/pass/index/progress/counter values for every cycle.
module tb_hf_result_scoreboard;
    localparam int DEPTH = 8;
    localparam int MAXE  = 20;
    localparam int RINT  = 4;

    logic        clk;
    logic        reset_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] exp_ieee;
    logic [32:0] exp_recoded;
    logic [4:0]  exp_exc;
    logic        res_valid;
    logic [31:0] res_ieee;
    logic [32:0] res_recoded;
    logic [4:0]  res_exc;
    logic        check;
    logic        pass;
    logic [31:0] mis_index;
    logic [31:0] test_count;
    logic [15:0] error_count;
    logic        progress;
    logic        underflow_err;
    logic        abort;

    hf_result_scoreboard #(
        .EXP_W(8), .SIG_W(24), .DEPTH(DEPTH), .MAX_ERRORS(MAXE), .REPORT_INT(RINT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .exp_ieee(exp_ieee), .exp_recoded(exp_recoded), .exp_exc(exp_exc),
        .res_valid(res_valid), .res_ieee(res_ieee), .res_recoded(res_recoded),
        .res_exc(res_exc),
        .check(check), .pass(pass), .mis_index(mis_index), .test_count(test_count),
        .error_count(error_count), .progress(progress), .underflow_err(underflow_err),
        .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: queue of triples {ieee, recoded, exc} held by the DUT FIFO.
    logic [69:0] q[$];
    int          m_tests;
    int          m_errs;
    bit          m_abort;
    bit          m_under;
    int          m_idx;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [69:0] rvec();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[69:0];
    endfunction

    task automatic model_clear();
        q.delete();
        m_tests = 0;
        m_errs  = 0;
        m_abort = 0;
        m_under = 0;
        m_idx   = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(issue_ready), 64'd0);
        chk({tag, "_check"}, 64'(check), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_idx"}, 64'(mis_index), 64'd0);
        chk({tag, "_tests"}, 64'(test_count), 64'd0);
        chk({tag, "_errs"}, 64'(error_count), 64'd0);
        chk({tag, "_prog"}, 64'(progress), 64'd0);
        chk({tag, "_under"}, 64'(underflow_err), 64'd0);
        chk({tag, "_abort"}, 64'(abort), 64'd0);
    endtask

    // Called at a negedge; asserts reset asynchronously between edges.
    task automatic do_reset(input string tag);
        #2;
        reset_n     = 1'b0;
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        #1;
        chk_all_zero(tag);
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: drive at negedge, predict, clock, check at the next negedge.
    task automatic step(input logic iv, input logic [69:0] it,
                        input logic rv, input logic [69:0] rt);
        bit          push_ok, pop_ok, e_check, e_pass, e_prog;
        logic [69:0] head;
        issue_valid = iv;
        {exp_ieee, exp_recoded, exp_exc} = it;
        res_valid = rv;
        {res_ieee, res_recoded, res_exc} = rt;
        #1;
        chk("ready", 64'(issue_ready), 64'(q.size() < DEPTH && !m_abort));
        push_ok = iv && q.size() < DEPTH && !m_abort;
        pop_ok  = rv && q.size() > 0 && !m_abort;
        if (rv && q.size() == 0 && !m_abort) m_under = 1;
        e_check = 0; e_pass = 0; e_prog = 0;
        if (pop_ok) begin
            head    = q.pop_front();
            e_check = 1;
            e_pass  = (head == rt);
            e_prog  = (m_tests % RINT) == 0;
            m_idx   = m_tests;
            m_tests++;
            if (!e_pass) begin
                m_errs++;
                if (m_errs == MAXE) m_abort = 1;
            end
        end
        if (push_ok) q.push_back(it);
        @(posedge clk);
        @(negedge clk);
        chk("check", 64'(check), 64'(e_check));
        chk("pass", 64'(pass), 64'(e_pass));
        chk("progress", 64'(progress), 64'(e_prog));
        chk("test_count", 64'(test_count), 64'(m_tests));
        chk("error_count", 64'(error_count), 64'(m_errs));
        chk("abort", 64'(abort), 64'(m_abort));
        chk("underflow", 64'(underflow_err), 64'(m_under));
        if (e_check) chk("mis_index", 64'(mis_index), 64'(m_idx));
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) step(1'b0, '0, 1'b1, q[0]);
    endtask

    initial begin
        logic [69:0] v[3];
        logic [69:0] t;
        reset_n = 1'b0;
        issue_valid = 1'b0; res_valid = 1'b0;
        exp_ieee = '0; exp_recoded = '0; exp_exc = '0;
        res_ieee = '0; res_recoded = '0; res_exc = '0;
        model_clear();
        #1;
        chk_all_zero("rst0");
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // three vectors, results returned at latency 2
        for (int i = 0; i < 3; i++) v[i] = rvec();
        for (int i = 0; i < 5; i++)
            step(i < 3, (i < 3) ? v[i] : 70'h0, i >= 2, (i >= 2) ? v[i-2] : 70'h0);
        chk("tests_after3", 64'(test_count), 64'd3);

        // exception-flag-only mismatch
        t = rvec();
        t[4:0] = 5'h00;
        step(1'b1, t, 1'b0, '0);
        step(1'b0, '0, 1'b1, t | 70'h1);
        chk("err_after_exc", 64'(error_count), 64'd1);

        // fill, overflow drop, pop at full with refused push
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rvec(), 1'b0, '0);
        step(1'b1, rvec(), 1'b1, q[0]);
        drain();

        // underflow, including same-cycle push into an empty FIFO
        step(1'b0, '0, 1'b1, rvec());
        t = rvec();
        step(1'b1, t, 1'b1, t);
        drain();

        // passing results across progress intervals
        for (int i = 0; i < 9; i++) begin
            t = rvec();
            step(1'b1, t, 1'b0, '0);
            step(1'b0, '0, 1'b1, t);
        end

        // reset with FIFO half full, then a result must see an empty FIFO
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, rvec(), 1'b0, '0);
        do_reset("rstmid");
        step(1'b0, '0, 1'b1, rvec());
        do_reset("rst2");

        // error limit: pipelined mismatches until abort, then inert
        step(1'b1, rvec(), 1'b0, '0);
        for (int i = 0; i < MAXE + 4; i++)
            step(1'b1, rvec(), q.size() > 0, (q.size() > 0) ? (q[0] ^ (70'h1 << 40)) : 70'h0);
        chk("err_limit", 64'(error_count), 64'(MAXE));
        chk("abort_set", 64'(abort), 64'd1);
        do_reset("rst3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
